alu_branch_unit: RTL and testbench

Parametrised, registered execute stage for the eight-bit microprocessor. It decodes `aluop`/`funct`, performs the data operation or PC-relative branch, and holds zero/carry flags across instructions. It also counts taken branches. It sits between the main decoder and register/PC writeback, with a valid/ready handshake on both sides, so the datapath can stall.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_branch_dec.sv | 42 ++++
 rtl/alu_branch_unit.sv | 158 +++++++++++++++
 tb/tb_alu_branch_unit.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the execute stage: aluop/funct fields and the decoded op.
package alu_pkg;

  localparam logic [1:0] ALUOP_PASS  = 2'b00;
  localparam logic [1:0] ALUOP_ADDI  = 2'b01;
  localparam logic [1:0] ALUOP_SUBI  = 2'b10;
  localparam logic [1:0] ALUOP_RTYPE = 2'b11;

  localparam logic [1:0] FN_BZF = 2'd0;
  localparam logic [1:0] FN_BZB = 2'd1;
  localparam logic [1:0] FN_BF  = 2'd2;
  localparam logic [1:0] FN_BB  = 2'd3;

  typedef enum logic [2:0] {
    PASS,
    ADD,
    SUB,
    BZF,
    BZB,
    BF,
    BB,
    ILL
  } alu_op_t;

endpackage

// File: rtl/alu_branch_dec.sv
// Combinational decode of aluop/funct into a single execute op.
module alu_branch_dec
  import alu_pkg::*;
#(
  parameter int FUNCT_W = 2
) (
  input  logic [1:0]         aluop,
  input  logic [FUNCT_W-1:0] funct,
  output alu_op_t            op
);

  logic fn_hi;

  // Encodings above 3 exist only when funct is wider than two bits.
  if (FUNCT_W > 2) begin : g_hi
    assign fn_hi = |funct[FUNCT_W-1:2];
  end else begin : g_nohi
    assign fn_hi = 1'b0;
  end

  always_comb begin
    op = PASS;
    case (aluop)
      ALUOP_PASS: op = PASS;
      ALUOP_ADDI: op = ADD;
      ALUOP_SUBI: op = SUB;
      default: begin
        if (fn_hi) begin
          op = ILL;
        end else begin
          case (funct[1:0])
            FN_BZF:  op = BZF;
            FN_BZB:  op = BZB;
            FN_BF:   op = BF;
            default: op = BB;
          endcase
        end
      end
    endcase
  end

endmodule

// File: rtl/alu_branch_unit.sv
// Registered execute stage: data ops, PC-relative branches, zero/carry flags,
// valid/ready handshake on both sides and a saturating taken-branch counter.
module alu_branch_unit
  import alu_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int PC_W     = 8,
  parameter int FUNCT_W  = 2,
  parameter int COND_SRC = 0,
  parameter int CNT_W    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         aluop,
  input  logic [FUNCT_W-1:0] funct,
  input  logic [WIDTH-1:0]   acc,
  input  logic [WIDTH-1:0]   data,
  input  logic [PC_W-1:0]    pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic               result_we,
  output logic [PC_W-1:0]    pc_next,
  output logic               branch_taken,
  output logic               illegal,
  output logic               zero_flag,
  output logic               carry_flag,
  input  logic               cnt_clear,
  output logic [CNT_W-1:0]   taken_cnt
);

  alu_op_t          op;
  logic             accept;
  logic             cond;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [PC_W-1:0]  off;
  logic [PC_W-1:0]  pc_inc;
  logic [PC_W-1:0]  pc_fwd;
  logic [PC_W-1:0]  pc_bwd;
  logic [WIDTH-1:0] res_n;
  logic [PC_W-1:0]  pc_n;
  logic             we_n;
  logic             take_n;
  logic             ill_n;
  logic             flag_upd;
  logic             carry_n;
  logic             zero_n;

  alu_branch_dec #(.FUNCT_W(FUNCT_W)) u_dec (
    .aluop (aluop),
    .funct (funct),
    .op    (op)
  );

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  assign sum    = {1'b0, acc} + {1'b0, data};
  // Borrow shows up as the extra top bit going high when acc < data.
  assign diff   = {1'b0, acc} - {1'b0, data};
  assign off    = PC_W'(data);
  assign pc_inc = pc + PC_W'(1);
  assign pc_fwd = pc + off;
  assign pc_bwd = pc - off;
  assign cond   = (COND_SRC != 0) ? zero_flag : (acc == '0);

  always_comb begin
    res_n    = '0;
    pc_n     = pc_inc;
    we_n     = 1'b0;
    take_n   = 1'b0;
    ill_n    = 1'b0;
    flag_upd = 1'b0;
    carry_n  = 1'b0;
    case (op)
      PASS: begin
        res_n    = data;
        we_n     = 1'b1;
        flag_upd = 1'b1;
      end
      ADD: begin
        res_n    = sum[WIDTH-1:0];
        carry_n  = sum[WIDTH];
        we_n     = 1'b1;
        flag_upd = 1'b1;
      end
      SUB: begin
        res_n    = diff[WIDTH-1:0];
        carry_n  = diff[WIDTH];
        we_n     = 1'b1;
        flag_upd = 1'b1;
      end
      BZF: begin
        if (cond) begin
          take_n = 1'b1;
          pc_n   = pc_fwd;
        end
      end
      BZB: begin
        if (cond) begin
          take_n = 1'b1;
          pc_n   = pc_bwd;
        end
      end
      BF: begin
        take_n = 1'b1;
        pc_n   = pc_fwd;
      end
      BB: begin
        take_n = 1'b1;
        pc_n   = pc_bwd;
      end
      default: ill_n = 1'b1;
    endcase
  end

  assign zero_n = (res_n == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid    <= 1'b0;
      result       <= '0;
      result_we    <= 1'b0;
      pc_next      <= '0;
      branch_taken <= 1'b0;
      illegal      <= 1'b0;
      zero_flag    <= 1'b0;
      carry_flag   <= 1'b0;
    end else if (accept) begin
      out_valid    <= 1'b1;
      result       <= res_n;
      result_we    <= we_n;
      pc_next      <= pc_n;
      branch_taken <= take_n;
      illegal      <= ill_n;
      if (flag_upd) begin
        zero_flag  <= zero_n;
        carry_flag <= carry_n;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      taken_cnt <= '0;
    end else if (cnt_clear) begin
      taken_cnt <= '0;
    end else if (accept && take_n && (taken_cnt != '1)) begin
      taken_cnt <= taken_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_branch_unit.sv
// Directed bench: two configurations driven in parallel and checked against a
// behavioural model every cycle, plus literal expectations at key points.
module tb_alu_branch_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid, out_ready, cnt_clear;
  logic [1:0] aluop;
  logic [2:0] funct;
  logic [7:0] acc, data, pc;

  logic        rdy0, vld0, we0, tk0, il0, z0, c0;
  logic [7:0]  res0, pcn0;
  logic [15:0] cnt0;
  logic        rdy1, vld1, we1, tk1, il1, z1, c1;
  logic [7:0]  res1, pcn1;
  logic [1:0]  cnt1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Instance 0: default widths, branch condition taken from acc at issue.
  alu_branch_unit #(.WIDTH(8), .PC_W(8), .FUNCT_W(2), .COND_SRC(0), .CNT_W(16)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy0),
    .aluop(aluop), .funct(funct[1:0]), .acc(acc), .data(data), .pc(pc),
    .out_valid(vld0), .out_ready(out_ready), .result(res0), .result_we(we0),
    .pc_next(pcn0), .branch_taken(tk0), .illegal(il0), .zero_flag(z0),
    .carry_flag(c0), .cnt_clear(cnt_clear), .taken_cnt(cnt0)
  );

  // Instance 1: stored-flag condition, 3-bit funct, 2-bit counter.
  alu_branch_unit #(.WIDTH(8), .PC_W(8), .FUNCT_W(3), .COND_SRC(1), .CNT_W(2)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy1),
    .aluop(aluop), .funct(funct), .acc(acc), .data(data), .pc(pc),
    .out_valid(vld1), .out_ready(out_ready), .result(res1), .result_we(we1),
    .pc_next(pcn1), .branch_taken(tk1), .illegal(il1), .zero_flag(z1),
    .carry_flag(c1), .cnt_clear(cnt_clear), .taken_cnt(cnt1)
  );

  int p_cs[2]   = '{0, 1};
  int p_fw[2]   = '{2, 3};
  int p_cmax[2] = '{65535, 3};

  int m_vld[2] = '{0, 0};
  int m_res[2] = '{0, 0};
  int m_we[2]  = '{0, 0};
  int m_pc[2]  = '{0, 0};
  int m_tk[2]  = '{0, 0};
  int m_il[2]  = '{0, 0};
  int m_z[2]   = '{0, 0};
  int m_c[2]   = '{0, 0};
  int m_cnt[2] = '{0, 0};

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_step(input int k);
    int a, d, p, f, res, we, pcn, tk, il, upd, c, cond, ok;
    a = int'(acc); d = int'(data); p = int'(pc);
    ok = (in_valid && (m_vld[k] == 0 || out_ready)) ? 1 : 0;
    tk = 0;
    if (ok != 0) begin
      res = 0; we = 0; pcn = (p + 1) % 256; il = 0; upd = 0; c = 0;
      case (int'(aluop))
        0: begin res = d; we = 1; upd = 1; end
        1: begin res = (a + d) % 256; c = (a + d > 255) ? 1 : 0; we = 1; upd = 1; end
        2: begin res = (a - d + 256) % 256; c = (a < d) ? 1 : 0; we = 1; upd = 1; end
        default: begin
          f = int'(funct) % (1 << p_fw[k]);
          if (f >= 4) begin
            il = 1;
          end else begin
            cond = (p_cs[k] != 0) ? m_z[k] : ((a == 0) ? 1 : 0);
            if (f >= 2 || cond != 0) begin
              tk = 1;
              pcn = (f % 2 == 0) ? (p + d) % 256 : (p - d + 256) % 256;
            end
          end
        end
      endcase
      m_vld[k] = 1; m_res[k] = res; m_we[k] = we; m_pc[k] = pcn;
      m_tk[k] = tk; m_il[k] = il;
      if (upd != 0) begin
        m_z[k] = (res == 0) ? 1 : 0;
        m_c[k] = c;
      end
    end else if (out_ready) begin
      m_vld[k] = 0;
    end
    if (cnt_clear) m_cnt[k] = 0;
    else if (ok != 0 && tk != 0 && m_cnt[k] < p_cmax[k]) m_cnt[k] = m_cnt[k] + 1;
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 2; k++) begin
        m_vld[k] = 0; m_res[k] = 0; m_we[k] = 0; m_pc[k] = 0; m_tk[k] = 0;
        m_il[k] = 0; m_z[k] = 0; m_c[k] = 0; m_cnt[k] = 0;
      end
    end else begin
      model_step(0);
      model_step(1);
    end
  end

  task automatic cmp(input int k, input int rdy, input int vld, input int res,
                     input int we, input int pcn, input int tk, input int il,
                     input int z, input int c, input int cnt);
    string s;
    s = $sformatf("dut%0d", k);
    chk({s, ".in_ready"},   rdy, (m_vld[k] == 0 || out_ready) ? 1 : 0);
    chk({s, ".out_valid"},  vld, m_vld[k]);
    chk({s, ".zero_flag"},  z,   m_z[k]);
    chk({s, ".carry_flag"}, c,   m_c[k]);
    chk({s, ".taken_cnt"},  cnt, m_cnt[k]);
    if (m_vld[k] != 0) begin
      chk({s, ".result"},       res, m_res[k]);
      chk({s, ".result_we"},    we,  m_we[k]);
      chk({s, ".pc_next"},      pcn, m_pc[k]);
      chk({s, ".branch_taken"}, tk,  m_tk[k]);
      chk({s, ".illegal"},      il,  m_il[k]);
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      cmp(0, int'(rdy0), int'(vld0), int'(res0), int'(we0), int'(pcn0), int'(tk0),
          int'(il0), int'(z0), int'(c0), int'(cnt0));
      cmp(1, int'(rdy1), int'(vld1), int'(res1), int'(we1), int'(pcn1), int'(tk1),
          int'(il1), int'(z1), int'(c1), int'(cnt1));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [2:0] fn,
                       input logic [7:0] a, input logic [7:0] d, input logic [7:0] p);
    aluop = op; funct = fn; acc = a; data = d; pc = p; in_valid = 1'b1;
    tick();
  endtask

  task automatic idle();
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
  endtask

  initial begin
    in_valid = 1'b0; out_ready = 1'b1; cnt_clear = 1'b0;
    aluop = 2'd0; funct = 3'd0; acc = 8'h00; data = 8'h00; pc = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", int'(vld1), 0);
    chk("reset in_ready", int'(rdy1), 1);
    chk("reset taken_cnt", int'(cnt0), 0);
    chk("reset pc_next", int'(pcn1), 0);
    chk("reset zero_flag", int'(z1), 0);
    reset = 1'b0;

    issue(2'd1, 3'd0, 8'hF0, 8'h20, 8'h30);
    chk("addi out_valid latency", int'(vld1), 1);
    chk("addi result", int'(res1), 'h10);
    chk("addi carry", int'(c1), 1);
    chk("addi zero", int'(z1), 0);
    chk("addi pc_next", int'(pcn1), 'h31);

    issue(2'd2, 3'd0, 8'h05, 8'h05, 8'h0F);
    chk("subi zero", int'(z1), 1);
    chk("subi carry", int'(c1), 0);

    issue(2'd3, 3'd0, 8'h07, 8'h04, 8'h10);
    chk("bzf flag pc_next", int'(pcn1), 'h14);
    chk("bzf flag taken", int'(tk1), 1);
    chk("bzf flag taken_cnt", int'(cnt1), 1);
    chk("bzf acc pc_next", int'(pcn0), 'h11);
    chk("bzf acc taken", int'(tk0), 0);

    issue(2'd3, 3'd3, 8'h07, 8'h05, 8'h02);
    chk("bb wrap pc_next", int'(pcn1), 'hFD);
    chk("bb result_we", int'(we1), 0);
    chk("bb taken_cnt", int'(cnt1), 2);

    idle();
    chk("drain out_valid", int'(vld1), 0);

    out_ready = 1'b0;
    issue(2'd1, 3'd0, 8'h01, 8'h01, 8'h40);
    chk("stall first result", int'(res1), 2);
    aluop = 2'd0; data = 8'h00; pc = 8'h50; in_valid = 1'b1;
    repeat (3) begin
      tick();
      chk("stall in_ready", int'(rdy1), 0);
      chk("stall result", int'(res1), 2);
      chk("stall zero", int'(z1), 0);
    end
    out_ready = 1'b1;
    #1;
    chk("release in_ready", int'(rdy1), 1);
    tick();
    chk("release result", int'(res1), 0);
    chk("release zero", int'(z1), 1);
    chk("release pc_next", int'(pcn1), 'h51);

    repeat (5) issue(2'd3, 3'd2, 8'h07, 8'h01, 8'h60);
    chk("saturated taken_cnt", int'(cnt1), 3);
    chk("wide taken_cnt", int'(cnt0), 6);
    chk("bf pc_next", int'(pcn1), 'h61);
    cnt_clear = 1'b1;
    issue(2'd3, 3'd2, 8'h07, 8'h01, 8'h60);
    cnt_clear = 1'b0;
    chk("clear wins cnt1", int'(cnt1), 0);
    chk("clear wins cnt0", int'(cnt0), 0);

    issue(2'd3, 3'd1, 8'h00, 8'h10, 8'h05);
    chk("bzb taken dut0", int'(pcn0), 'hF5);
    chk("bzb taken dut1", int'(pcn1), 'hF5);
    issue(2'd1, 3'd0, 8'h00, 8'h01, 8'h20);
    issue(2'd3, 3'd1, 8'h00, 8'h10, 8'h05);
    chk("bzb acc cond", int'(pcn0), 'hF5);
    chk("bzb flag cond", int'(pcn1), 'h06);

    issue(2'd3, 3'd5, 8'h03, 8'h02, 8'h70);
    chk("illegal flag", int'(il1), 1);
    chk("illegal pc_next", int'(pcn1), 'h71);
    chk("illegal result_we", int'(we1), 0);
    chk("illegal taken_cnt", int'(cnt1), 1);
    chk("narrow funct not illegal", int'(il0), 0);

    idle();
    out_ready = 1'b0;
    issue(2'd0, 3'd0, 8'h00, 8'hAA, 8'h80);
    chk("pre-reset result", int'(res1), 'hAA);
    #2;
    reset = 1'b1;
    #1;
    chk("async reset out_valid1", int'(vld1), 0);
    chk("async reset out_valid0", int'(vld0), 0);
    chk("async reset result", int'(res1), 0);
    tick();
    reset = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
